hbidle_fifo: RTL and testbench



---
 rtl/hbidle_pkg.sv | 18 +
 rtl/hbidle_sfifo.sv | 67 ++++++
 rtl/hbidle_fifo.sv | 107 ++++++++++
 tb/tb_hbidle_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hbidle_pkg.sv
// Shared hexbus definitions for the idle/keep-alive stage.
package hbidle_pkg;

    // Five-bit prefix that marks a keep-alive word on the hexbus
    localparam logic [4:0] IDLE_SUB_WORD = 5'b11011;

    // Native hexbus word width
    localparam int DEFAULT_DW = 34;

    // Build the keep-alive word: the prefix in the top five bits, zeros below.
    // Word widths up to 64 bits are supported; callers truncate to their width.
    function automatic logic [63:0] make_idle_word(input int dw);
        logic [63:0] w_word;
        w_word = 64'(IDLE_SUB_WORD) << (dw - 5);
        return w_word;
    endfunction

endpackage

// File: rtl/hbidle_sfifo.sv
// Small synchronous FIFO with look-ahead head data, registered full/empty.
module hbidle_sfifo
    import hbidle_pkg::*;
#(
    parameter int LGFIFO = 2,
    parameter int DW     = DEFAULT_DW
)(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_write,
    input  logic [DW-1:0] i_data,
    output logic          o_full,
    input  logic          i_read,
    output logic          o_empty,
    output logic [DW-1:0] o_data
);

    localparam int DEPTH = 1 << LGFIFO;

    logic [DW-1:0]     r_mem [DEPTH];
    logic [LGFIFO-1:0] r_wr_ptr;
    logic [LGFIFO-1:0] r_rd_ptr;
    logic [LGFIFO:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic [LGFIFO:0]   w_count_next;

    // Occupancy after this cycle's write and read
    always_comb begin
        w_count_next = r_count;
        if (i_write && !i_read)
            w_count_next = r_count + 1'b1;
        else if (!i_write && i_read)
            w_count_next = r_count - 1'b1;
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge i_clk) begin
        if (i_write)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (i_write)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_read)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == (LGFIFO+1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Head word is visible without a read strobe so the output stage can load it
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/hbidle_fifo.sv
// Hexbus idle stage: buffers response words and injects keep-alive words
// after a programmable number of quiet cycles.
module hbidle_fifo
    import hbidle_pkg::*;
#(
    parameter int            DW        = DEFAULT_DW,
    parameter int            LGFIFO    = 2,
    parameter int            TW        = 30,
    parameter logic [DW-1:0] IDLE_WORD = DW'(make_idle_word(DW))
)(
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_stb,
    input  logic [DW-1:0] i_cmd_word,
    output logic          o_idl_busy,
    input  logic [TW-1:0] i_timeout,
    output logic          o_idl_stb,
    output logic [DW-1:0] o_idl_word,
    input  logic          i_busy,
    output logic [15:0]   o_keepalives
);

    logic          r_stb;
    logic [DW-1:0] r_word;
    logic [TW-1:0] r_idle_count;
    logic [15:0]   r_keepalives;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [DW-1:0] w_fifo_data;
    logic          w_accept;
    logic          w_xfer;
    logic          w_out_free;
    logic          w_bypass;
    logic          w_fifo_write;
    logic          w_fifo_read;
    logic          w_timeout_off;
    logic          w_fire;

    assign w_accept      = i_cmd_stb && !w_fifo_full;
    assign w_xfer        = r_stb && !i_busy;
    assign w_out_free    = !r_stb || !i_busy;
    // An empty FIFO with a free output register lets the word skip the queue
    assign w_bypass      = w_accept && w_fifo_empty && w_out_free;
    assign w_fifo_write  = w_accept && !w_bypass;
    assign w_fifo_read   = !w_fifo_empty && w_out_free;
    assign w_timeout_off = (i_timeout == '0);
    // Accepted input suppresses a keep-alive due in the same cycle
    assign w_fire        = !w_timeout_off && (r_idle_count == i_timeout - TW'(1))
                           && !r_stb && w_fifo_empty && !w_accept;

    hbidle_sfifo #(
        .LGFIFO (LGFIFO),
        .DW     (DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_write (w_fifo_write),
        .i_data  (i_cmd_word),
        .o_full  (w_fifo_full),
        .i_read  (w_fifo_read),
        .o_empty (w_fifo_empty),
        .o_data  (w_fifo_data)
    );

    // Output register: queued data first, then bypass data, then keep-alive
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stb  <= 1'b0;
            r_word <= IDLE_WORD;
        end else if (w_fifo_read) begin
            r_stb  <= 1'b1;
            r_word <= w_fifo_data;
        end else if (w_bypass) begin
            r_stb  <= 1'b1;
            r_word <= i_cmd_word;
        end else if (w_fire) begin
            r_stb  <= 1'b1;
            r_word <= IDLE_WORD;
        end else if (w_xfer) begin
            r_stb  <= 1'b0;
            r_word <= IDLE_WORD;
        end
    end

    // Quiet-cycle counter; counts only while nothing is pending anywhere
    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept || w_xfer || w_timeout_off || w_fire)
            r_idle_count <= '0;
        else if (!r_stb && w_fifo_empty)
            r_idle_count <= r_idle_count + 1'b1;
    end

    // Saturating count of keep-alive words issued
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_keepalives <= '0;
        else if (w_fire && (r_keepalives != 16'hffff))
            r_keepalives <= r_keepalives + 1'b1;
    end

    assign o_idl_busy   = w_fifo_full;
    assign o_idl_stb    = r_stb;
    assign o_idl_word   = r_word;
    assign o_keepalives = r_keepalives;

endmodule

// File: tb/tb_hbidle_fifo.sv
// Directed bench for the hexbus idle stage.
module tb_hbidle_fifo;

    localparam int DW = 34;
    localparam int TW = 30;
    localparam logic [DW-1:0] IDLE = 34'h3_6000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_stb;
    logic [DW-1:0] cmd_word;
    logic          idl_busy;
    logic [TW-1:0] timeout;
    logic          idl_stb;
    logic [DW-1:0] idl_word;
    logic          busy;
    logic [15:0]   keepalives;

    int checks = 0;
    int errors = 0;
    int stb_seen;
    logic [DW-1:0] burst [5];

    hbidle_fifo dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_cmd_stb    (cmd_stb),
        .i_cmd_word   (cmd_word),
        .o_idl_busy   (idl_busy),
        .i_timeout    (timeout),
        .o_idl_stb    (idl_stb),
        .o_idl_word   (idl_word),
        .i_busy       (busy),
        .o_keepalives (keepalives)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_stb = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_stb = 1'b0; cmd_word = '0; busy = 1'b0; timeout = 30'd8;
        burst[0] = 34'h0_0000_0011; burst[1] = 34'h0_0000_0022; burst[2] = 34'h0_0000_0033;
        burst[3] = 34'h0_0000_0044; burst[4] = 34'h0_0000_0055;

        // --- Reset state and periodic keep-alives with timeout 8 ---
        do_reset();
        check("rst_stb", 34'(idl_stb), 34'd0);
        check("rst_word", idl_word, IDLE);
        check("rst_busy", 34'(idl_busy), 34'd0);
        check("rst_ka", 34'(keepalives), 34'd0);
        for (int k = 1; k <= 27; k++) begin
            step();
            check($sformatf("ka_stb_c%0d", k), 34'(idl_stb), 34'((k % 9) == 8));
            if ((k % 9) == 8)
                check($sformatf("ka_word_c%0d", k), idl_word, IDLE);
            $display("ka cycle %0d stb=%0b word=%h count=%0d", k, idl_stb, idl_word, keepalives);
        end
        check("ka_count_27", 34'(keepalives), 34'd3);

        // --- Timeout 0 disables keep-alives ---
        timeout = 30'd0;
        do_reset();
        stb_seen = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (idl_stb) stb_seen++;
        end
        $display("timeout0 1000 cycles stb_seen=%0d count=%0d", stb_seen, keepalives);
        check("to0_stb_seen", 34'(stb_seen), 34'd0);
        check("to0_ka", 34'(keepalives), 34'd0);

        // --- Single word, latency 1, then back to idle ---
        cmd_stb = 1'b1; cmd_word = 34'h1_2345_6789;
        step();
        cmd_stb = 1'b0;
        $display("single word stb=%0b word=%h", idl_stb, idl_word);
        check("single_stb", 34'(idl_stb), 34'd1);
        check("single_word", idl_word, 34'h1_2345_6789);
        step();
        check("single_after_stb", 34'(idl_stb), 34'd0);
        check("single_after_word", idl_word, IDLE);

        // --- Burst of 5 while stalled, then drain in order ---
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_stb = 1'b1; cmd_word = burst[i];
            step();
            $display("burst write %0d word=%h busy_out=%0b", i, burst[i], idl_busy);
            check($sformatf("burst_busy_w%0d", i), 34'(idl_busy), 34'(i == 4));
        end
        cmd_stb = 1'b0;
        step();
        check("stall_hold_stb", 34'(idl_stb), 34'd1);
        check("stall_hold_word", idl_word, burst[0]);
        busy = 1'b0;
        for (int i = 1; i < 5; i++) begin
            step();
            $display("drain %0d stb=%0b word=%h", i, idl_stb, idl_word);
            check($sformatf("drain_word_%0d", i), idl_word, burst[i]);
            check($sformatf("drain_busy_%0d", i), 34'(idl_busy), 34'd0);
        end
        step();
        check("drain_done_stb", 34'(idl_stb), 34'd0);
        check("drain_done_word", idl_word, IDLE);

        // --- Input collides with keep-alive fire at count 3 (timeout 4) ---
        timeout = 30'd4;
        do_reset();
        step(); step(); step();
        cmd_stb = 1'b1; cmd_word = 34'h2_AAAA_5555;
        step();
        cmd_stb = 1'b0;
        $display("race stb=%0b word=%h count=%0d", idl_stb, idl_word, keepalives);
        check("race_word", idl_word, 34'h2_AAAA_5555);
        check("race_ka", 34'(keepalives), 34'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("race_after_stb_%0d", k), 34'(idl_stb), 34'(k == 5));
        end
        check("race_ka_word", idl_word, IDLE);
        check("race_ka_count", 34'(keepalives), 34'd1);

        // --- Reset while stalled with 3 words held ---
        timeout = 30'd0;
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_stb = 1'b1; cmd_word = burst[i];
            step();
        end
        cmd_stb = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("midreset stb=%0b busy_out=%0b word=%h", idl_stb, idl_busy, idl_word);
        check("midrst_stb", 34'(idl_stb), 34'd0);
        check("midrst_busy", 34'(idl_busy), 34'd0);
        check("midrst_word", idl_word, IDLE);
        busy = 1'b0;
        stb_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (idl_stb) stb_seen++;
        end
        check("midrst_no_stale", 34'(stb_seen), 34'd0);
        cmd_stb = 1'b1; cmd_word = 34'h0_DEAD_BEEF;
        step();
        cmd_stb = 1'b0;
        check("midrst_new_word", idl_word, 34'h0_DEAD_BEEF);
        check("midrst_new_stb", 34'(idl_stb), 34'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
